// File: rtl/clk_freq_pkg.sv
// Shared definitions for the user_clk frequency counter: FSM encoding and
// result-width constants.
package clk_freq_pkg;

  localparam int RESULT_W = 32;
  localparam logic [RESULT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2
  } state_t;

endpackage

// File: rtl/pps_sync_edge.sv
// Synchronizes the asynchronous pps_in into user_clk and emits a one-cycle
// pulse on each synchronized rising edge.
module pps_sync_edge #(
  parameter int C_SYNC_STAGES = 2
) (
  input  logic user_clk,
  input  logic user_rst_n,
  input  logic async_in,
  output logic edge_out
);

  logic [C_SYNC_STAGES-1:0] sync_reg;
  logic                     prev_reg;

  generate
    for (genvar gi = 0; gi < C_SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge user_clk or negedge user_rst_n) begin
          if (!user_rst_n) sync_reg[gi] <= 1'b0;
          else             sync_reg[gi] <= async_in;
        end
      end else begin : g_chain
        always_ff @(posedge user_clk or negedge user_rst_n) begin
          if (!user_rst_n) sync_reg[gi] <= 1'b0;
          else             sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) prev_reg <= 1'b0;
    else             prev_reg <= sync_reg[C_SYNC_STAGES-1];
  end

  assign edge_out = sync_reg[C_SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/clk_freq_counter.sv
// Counts user_clk cycles between accepted 1PPS edges and publishes the period.
// Optional no-edge timeout is enabled by defining CLK_FREQ_TIMEOUT_EN.
module clk_freq_counter
  import clk_freq_pkg::*;
#(
  parameter int                     C_CNT_WIDTH      = RESULT_W,
  parameter int                     C_SYNC_STAGES    = 2,
  parameter logic [C_CNT_WIDTH-1:0] C_MIN_PERIOD     = 32'd1000,
  parameter logic [C_CNT_WIDTH-1:0] C_TIMEOUT_CYCLES = 32'd400000000
) (
  input  logic                   user_clk,
  input  logic                   user_rst_n,
  input  logic                   pps_in,
  input  logic                   enable,
  output logic [C_CNT_WIDTH-1:0] user_data_out,
  output logic                   meas_strobe,
  output logic                   valid,
  output logic                   overflow,
  output logic                   pps_missing
);

  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = C_CNT_WIDTH'(1);

  logic                   pps_edge;
  state_t                 state_reg, state_next;
  logic [C_CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [C_CNT_WIDTH-1:0] data_reg, data_next;
  logic                   ovf_reg, ovf_next;
  logic                   valid_reg, valid_next;
  logic                   strobe_reg, strobe_next;
  logic                   missing_reg, missing_next;

  pps_sync_edge #(
    .C_SYNC_STAGES(C_SYNC_STAGES)
  ) u_sync (
    .user_clk  (user_clk),
    .user_rst_n(user_rst_n),
    .async_in  (pps_in),
    .edge_out  (pps_edge)
  );

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      data_reg    <= '0;
      ovf_reg     <= 1'b0;
      valid_reg   <= 1'b0;
      strobe_reg  <= 1'b0;
      missing_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      data_reg    <= data_next;
      ovf_reg     <= ovf_next;
      valid_reg   <= valid_next;
      strobe_reg  <= strobe_next;
      missing_reg <= missing_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    data_next    = data_reg;
    ovf_next     = ovf_reg;
    valid_next   = valid_reg;
    strobe_next  = 1'b0;
    missing_next = missing_reg;
    // Dropping enable overrides everything, including a coincident edge.
    if (!enable) begin
      state_next   = IDLE;
      cnt_next     = '0;
      valid_next   = 1'b0;
      missing_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_next   = '0;
          state_next = ARM;
        end
        ARM: begin
          if (pps_edge) begin
            cnt_next   = CNT_ONE;
            state_next = COUNT;
          end
        end
        COUNT: begin
          if (pps_edge && (cnt_reg >= C_MIN_PERIOD)) begin
            data_next    = cnt_reg;
            ovf_next     = (cnt_reg == CNT_MAX);
            valid_next   = 1'b1;
            strobe_next  = 1'b1;
            missing_next = 1'b0;
            cnt_next     = CNT_ONE;
          end else begin
            if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + CNT_ONE;
`ifdef CLK_FREQ_TIMEOUT_EN
            if (cnt_reg == C_TIMEOUT_CYCLES) begin
              missing_next = 1'b1;
              valid_next   = 1'b0;
              data_next    = '0;
              cnt_next     = '0;
              state_next   = ARM;
            end
`endif
          end
        end
        default: begin
          cnt_next   = '0;
          state_next = IDLE;
        end
      endcase
    end
  end

  assign user_data_out = data_reg;
  assign meas_strobe   = strobe_reg;
  assign valid         = valid_reg;
  assign overflow      = ovf_reg;
`ifdef CLK_FREQ_TIMEOUT_EN
  assign pps_missing   = missing_reg;
`else
  // Without the timeout there is nothing that can set the flag.
  assign pps_missing   = 1'b0;
`endif

endmodule

// File: tb/tb_clk_freq_counter.sv
// Directed self-checking bench for clk_freq_counter (C_MIN_PERIOD=4,
// C_TIMEOUT_CYCLES=1000, C_SYNC_STAGES=2).
module tb_clk_freq_counter;

  logic        user_clk = 1'b0;
  logic        user_rst_n = 1'b0;
  logic        pps_in = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] user_data_out;
  logic        meas_strobe;
  logic        valid;
  logic        overflow;
  logic        pps_missing;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int last_strobe_cyc = -1;

  always #5 user_clk = ~user_clk;

  clk_freq_counter #(
    .C_CNT_WIDTH     (32),
    .C_SYNC_STAGES   (2),
    .C_MIN_PERIOD    (32'd4),
    .C_TIMEOUT_CYCLES(32'd1000)
  ) dut (
    .user_clk     (user_clk),
    .user_rst_n   (user_rst_n),
    .pps_in       (pps_in),
    .enable       (enable),
    .user_data_out(user_data_out),
    .meas_strobe  (meas_strobe),
    .valid        (valid),
    .overflow     (overflow),
    .pps_missing  (pps_missing)
  );

  always @(posedge user_clk) cyc <= cyc + 1;

  always @(negedge user_clk) begin
    if (meas_strobe === 1'b1) begin
      strobe_cnt      <= strobe_cnt + 1;
      last_strobe_cyc <= cyc;
    end
  end

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge user_clk);
      #1;
    end
  endtask

  task automatic pps_pulse(input int period);
    pps_in = 1'b1;
    ticks(4);
    pps_in = 1'b0;
    ticks(period - 4);
  endtask

  task automatic rearm();
    enable = 1'b0;
    ticks(1);
    enable = 1'b1;
    ticks(2);
  endtask

  // Drives one pps rise and checks the publish it should cause 3 cycles later.
  task automatic pps_rise_check(input string name, input logic [31:0] exp_data, input logic exp_ovf);
    int rc;
    int s0;
    rc = cyc;
    s0 = strobe_cnt;
    pps_in = 1'b1;
    ticks(4);
    pps_in = 1'b0;
    tests_run++;
    if (user_data_out !== exp_data || valid !== 1'b1 || overflow !== exp_ovf) begin
      tests_failed++;
      $display("FAIL %s: data=%h valid=%b ovf=%b, expected data=%h valid=1 ovf=%b",
               name, user_data_out, valid, overflow, exp_data, exp_ovf);
    end
    tests_run++;
    if ((strobe_cnt - s0) !== 1 || (last_strobe_cyc - rc) !== 3) begin
      tests_failed++;
      $display("FAIL %s_strobe: strobes=%0d delay=%0d, expected strobes=1 delay=3",
               name, strobe_cnt - s0, last_strobe_cyc - rc);
    end
    $display("[TB] %s: data=%0d valid=%b ovf=%b", name, user_data_out, valid, overflow);
  endtask

  task automatic test_reset();
    ticks(3);
    tests_run++;
    if (user_data_out !== 32'd0 || meas_strobe !== 1'b0 || valid !== 1'b0 ||
        overflow !== 1'b0 || pps_missing !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hold: data=%h strobe=%b valid=%b ovf=%b miss=%b, expected all 0",
               user_data_out, meas_strobe, valid, overflow, pps_missing);
    end
    user_rst_n = 1'b1;
    enable = 1'b1;
    ticks(3);
    tests_run++;
    if (user_data_out !== 32'd0 || valid !== 1'b0 || strobe_cnt !== 0) begin
      tests_failed++;
      $display("FAIL reset_release: data=%h valid=%b strobes=%0d, expected 0 0 0",
               user_data_out, valid, strobe_cnt);
    end
    $display("[TB] reset: outputs cleared");
  endtask

  task automatic test_steady();
    int s0;
    s0 = strobe_cnt;
    pps_pulse(200);
    tests_run++;
    if (strobe_cnt !== s0) begin
      tests_failed++;
      $display("FAIL steady_first_edge: strobes=%0d, expected 0", strobe_cnt - s0);
    end
    pps_rise_check("steady_2nd", 32'd200, 1'b0);
    ticks(196);
    pps_rise_check("steady_3rd", 32'd200, 1'b0);
    ticks(196);
  endtask

  task automatic test_period_change();
    rearm();
    pps_pulse(200);
    pps_rise_check("period_200", 32'd200, 1'b0);
    ticks(146);
    pps_rise_check("period_150", 32'd150, 1'b0);
    ticks(46);
  endtask

  task automatic test_glitch();
    int s0;
    rearm();
    pps_pulse(200);
    s0 = strobe_cnt;
    pps_in = 1'b1;
    ticks(1);
    pps_in = 1'b0;
    ticks(2);
    pps_in = 1'b1;
    ticks(1);
    pps_in = 1'b0;
    ticks(196);
    tests_run++;
    if ((strobe_cnt - s0) !== 1 || user_data_out !== 32'd200) begin
      tests_failed++;
      $display("FAIL glitch_edge: strobes=%0d data=%0d, expected 1 and 200",
               strobe_cnt - s0, user_data_out);
    end
    pps_rise_check("glitch_next", 32'd200, 1'b0);
    ticks(46);
  endtask

  task automatic test_enable_drop();
    int s0;
    s0 = strobe_cnt;
    enable = 1'b0;
    ticks(1);
    tests_run++;
    if (valid !== 1'b0 || user_data_out !== 32'd200 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL enable_drop: valid=%b data=%0d ovf=%b, expected 0 200 0",
               valid, user_data_out, overflow);
    end
    ticks(10);
    enable = 1'b1;
    ticks(2);
    pps_pulse(200);
    tests_run++;
    if (strobe_cnt !== s0 || valid !== 1'b0 || user_data_out !== 32'd200) begin
      tests_failed++;
      $display("FAIL enable_first_edge: strobes=%0d valid=%b data=%0d, expected 0 0 200",
               strobe_cnt - s0, valid, user_data_out);
    end
    pps_rise_check("enable_resume", 32'd200, 1'b0);
    ticks(20);
    tests_run++;
    if (pps_missing !== 1'b0) begin
      tests_failed++;
      $display("FAIL enable_missing: pps_missing=%b, expected 0", pps_missing);
    end
  endtask

`ifdef CLK_FREQ_TIMEOUT_EN
  task automatic test_timeout();
    rearm();
    pps_pulse(1100);
    tests_run++;
    if (pps_missing !== 1'b1 || valid !== 1'b0 || user_data_out !== 32'd0) begin
      tests_failed++;
      $display("FAIL timeout: miss=%b valid=%b data=%0d, expected 1 0 0",
               pps_missing, valid, user_data_out);
    end
    pps_pulse(300);
    pps_rise_check("timeout_recover", 32'd300, 1'b0);
    tests_run++;
    if (pps_missing !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_clear: pps_missing=%b, expected 0", pps_missing);
    end
    ticks(20);
  endtask
`else
  task automatic test_timeout();
    int s0;
    rearm();
    s0 = strobe_cnt;
    pps_pulse(1100);
    tests_run++;
    if (pps_missing !== 1'b0 || strobe_cnt !== s0) begin
      tests_failed++;
      $display("FAIL no_timeout: miss=%b strobes=%0d, expected 0 0",
               pps_missing, strobe_cnt - s0);
    end
    $display("[TB] no_timeout: pps_missing=%b", pps_missing);
  endtask
`endif

  task automatic test_async_reset();
    int s0;
    rearm();
    pps_pulse(200);
    pps_rise_check("pre_reset", 32'd200, 1'b0);
    ticks(50);
    user_rst_n = 1'b0;
    #2;
    tests_run++;
    if (user_data_out !== 32'd0 || meas_strobe !== 1'b0 || valid !== 1'b0 ||
        overflow !== 1'b0 || pps_missing !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: data=%h strobe=%b valid=%b ovf=%b miss=%b, expected all 0",
               user_data_out, meas_strobe, valid, overflow, pps_missing);
    end
    ticks(2);
    user_rst_n = 1'b1;
    ticks(2);
    s0 = strobe_cnt;
    pps_pulse(200);
    tests_run++;
    if (strobe_cnt !== s0 || valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_first: strobes=%0d valid=%b, expected 0 0",
               strobe_cnt - s0, valid);
    end
    pps_rise_check("post_reset", 32'd200, 1'b0);
    ticks(20);
  endtask

  task automatic test_saturation();
    rearm();
    pps_pulse(20);
    force dut.cnt_reg = 32'hFFFF_FFFF;
    pps_rise_check("saturate", 32'hFFFF_FFFF, 1'b1);
    release dut.cnt_reg;
    rearm();
    pps_pulse(200);
    pps_rise_check("ovf_clear", 32'd200, 1'b0);
    ticks(20);
  endtask

  initial begin
    test_reset();
    test_steady();
    test_period_change();
    test_glitch();
    test_enable_drop();
    test_timeout();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
